// File: rtl/ook_tx_framer.sv
// ook_tx_framer: accepts bytes on a valid/ready stream and sends each one as an on-off-keyed frame.
// A frame is an alternating preamble, a start '1', 8 data bits LSB first and a stop '0'. A '1' bit bursts the carrier.
module ook_tx_framer #(
    parameter int CARRIER_HALF_PERIOD = 1000,
    parameter int BIT_PERIOD          = 20000,
    parameter int PREAMBLE_BITS       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    output logic       axiir,
    output logic       tx_out,
    output logic       busy
);

    localparam int BCW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int PCW = (CARRIER_HALF_PERIOD > 1) ? $clog2(CARRIER_HALF_PERIOD) : 1;
    localparam int IW  = $clog2(((PREAMBLE_BITS > 8) ? PREAMBLE_BITS : 8) + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_PERIOD - 1);
    localparam logic [PCW-1:0] PH_LAST   = PCW'(CARRIER_HALF_PERIOD - 1);
    localparam logic [IW-1:0]  PRE_LAST  = IW'(PREAMBLE_BITS - 1);
    localparam logic [IW-1:0]  DATA_LAST = IW'(7);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t         state_q, state_d;
    logic [7:0]     bufData_q, bufData_d;
    logic           bufValid_q, bufValid_d;
    logic [7:0]     shift_q, shift_d;
    logic [BCW-1:0] bitCnt_q, bitCnt_d;
    logic [IW-1:0]  bitIdx_q, bitIdx_d;
    logic [PCW-1:0] phase_q, phase_d;
    logic           carrier_q, carrier_d;
    logic           axiir_q, axiir_d;
    logic           txOut_q, txOut_d;
    logic           busy_q, busy_d;

    logic accept;
    logic bitEnd;
    logic loadBuf;
    logic bitVal;

    always_comb begin
        state_d    = state_q;
        bufData_d  = bufData_q;
        bufValid_d = bufValid_q;
        shift_d    = shift_q;
        bitCnt_d   = bitCnt_q;
        bitIdx_d   = bitIdx_q;
        phase_d    = phase_q;
        carrier_d  = carrier_q;
        loadBuf    = 1'b0;
        bitVal     = 1'b0;

        accept = axiiv && axiir_q;
        bitEnd = (bitCnt_q == BIT_LAST);

        if (state_q == IDLE) begin
            bitCnt_d  = '0;
            bitIdx_d  = '0;
            phase_d   = '0;
            carrier_d = 1'b1;
            if (bufValid_q) begin
                loadBuf = 1'b1;
                state_d = PREAMBLE;
            end
        end else begin
            // Every bit period restarts the carrier at phase 0, high, so each '1' bit looks identical.
            if (bitEnd) begin
                bitCnt_d  = '0;
                phase_d   = '0;
                carrier_d = 1'b1;
            end else begin
                bitCnt_d = bitCnt_q + BCW'(1);
                if (phase_q == PH_LAST) begin
                    phase_d   = '0;
                    carrier_d = ~carrier_q;
                end else begin
                    phase_d = phase_q + PCW'(1);
                end
            end

            if (bitEnd) begin
                case (state_q)
                    PREAMBLE: begin
                        if (bitIdx_q == PRE_LAST) begin
                            state_d  = START;
                            bitIdx_d = '0;
                        end else begin
                            bitIdx_d = bitIdx_q + IW'(1);
                        end
                    end
                    START: begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                    end
                    DATA: begin
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bitIdx_q == DATA_LAST) begin
                            state_d  = STOP;
                            bitIdx_d = '0;
                        end else begin
                            bitIdx_d = bitIdx_q + IW'(1);
                        end
                    end
                    STOP: begin
                        // A byte already waiting is chained straight into a new start bit without preamble.
                        if (bufValid_q) begin
                            loadBuf = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end

        if (loadBuf) begin
            shift_d    = bufData_q;
            bufValid_d = 1'b0;
        end
        if (accept) begin
            bufValid_d = 1'b1;
            bufData_d  = axiid;
        end

        case (state_q)
            PREAMBLE: bitVal = ~bitIdx_q[0];
            START:    bitVal = 1'b1;
            DATA:     bitVal = shift_q[0];
            default:  bitVal = 1'b0;
        endcase

        axiir_d = ~bufValid_d;
        txOut_d = bitVal & carrier_q;
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bufData_q  <= '0;
            bufValid_q <= 1'b0;
            shift_q    <= '0;
            bitCnt_q   <= '0;
            bitIdx_q   <= '0;
            phase_q    <= '0;
            carrier_q  <= 1'b1;
            axiir_q    <= 1'b0;
            txOut_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bufData_q  <= bufData_d;
            bufValid_q <= bufValid_d;
            shift_q    <= shift_d;
            bitCnt_q   <= bitCnt_d;
            bitIdx_q   <= bitIdx_d;
            phase_q    <= phase_d;
            carrier_q  <= carrier_d;
            axiir_q    <= axiir_d;
            txOut_q    <= txOut_d;
            busy_q     <= busy_d;
        end
    end

    assign axiir  = axiir_q;
    assign tx_out = txOut_q;
    assign busy   = busy_q;

endmodule
